// File: rtl/can_tx_fetch_pkg.sv
// Shared types and constants for the CAN transmit-frame fetch stage:
// FSM states, register map of the TX FIFO / HPB message words, and DLC helpers.
package can_tx_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_GAP  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } fetch_state_e;

  localparam logic [7:0] FIFO_ID_ADDR  = 8'h30;
  localparam logic [7:0] FIFO_DLC_ADDR = 8'h34;
  localparam logic [7:0] FIFO_DW1_ADDR = 8'h38;
  localparam logic [7:0] FIFO_DW2_ADDR = 8'h3C;
  localparam logic [7:0] HPB_ID_ADDR   = 8'h40;
  localparam logic [7:0] HPB_DLC_ADDR  = 8'h44;
  localparam logic [7:0] HPB_DW1_ADDR  = 8'h48;
  localparam logic [7:0] HPB_DW2_ADDR  = 8'h4C;
  localparam logic [7:0] WORD_STRIDE   = 8'h04;

  localparam int         DLC_MSB = 31;
  localparam int         DLC_LSB = 28;
  localparam logic [3:0] DLC_MAX = 4'd8;

  function automatic logic [3:0] dlc_clamp(input logic [3:0] raw);
    if (raw > DLC_MAX) return DLC_MAX;
    else return raw;
  endfunction

  // Number of data words still to read once the DLC is known.
  function automatic logic [1:0] dlc_data_words(input logic [3:0] dlc);
    if (dlc == 4'd0) return 2'd0;
    else if (dlc <= 4'd4) return 2'd1;
    else return 2'd2;
  endfunction

endpackage

// File: rtl/can_tx_fetch.sv
// Fetches one CAN frame (ID, DLC, data words) over the DEMUX read port and hands it downstream.
// Optional feature macro: CAN_TX_HPB_EN (honour hpb_req with priority over tx_req).
module can_tx_fetch
  import can_tx_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        sys_clk,
  input  logic        IP2Can_reset,
  input  logic        tx_req,
  input  logic        hpb_req,
  output logic        DEMUX2Can_CS,
  output logic [7:0]  DEMUX2Can_addr,
  input  logic [31:0] Can2DEMUX_data,
  input  logic        Can2DEMUX_ack,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [31:0] frame_id,
  output logic [3:0]  frame_dlc,
  output logic [63:0] frame_data,
  output logic        frame_is_hpb,
  output logic        fetch_error,
  output logic        busy
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_e state_r;
  fetch_state_e next_state_s;
  logic         cs_r;
  logic [7:0]   addr_r;
  logic [1:0]   idx_r;
  logic [7:0]   cnt_r;
  logic [31:0]  id_r;
  logic [31:0]  dw1_r;
  logic [31:0]  dw2_r;
  logic [3:0]   dlc_r;
  logic         is_hpb_r;
  logic         valid_r;
  logic         err_r;
  logic         busy_r;
  logic         hpb_sel_s;
  logic         start_s;
  logic         last_word_s;
  logic [3:0]   rx_dlc_s;

`ifdef CAN_TX_HPB_EN
  assign hpb_sel_s = hpb_req;
`else
  logic unused_hpb_req_s;
  assign unused_hpb_req_s = hpb_req;
  assign hpb_sel_s        = 1'b0;
`endif

  assign start_s  = hpb_sel_s | tx_req;
  assign rx_dlc_s = dlc_clamp(Can2DEMUX_data[DLC_MSB:DLC_LSB]);

  // Decide whether the word being acknowledged is the last one this frame needs.
  always_comb begin
    last_word_s = 1'b1;
    case (idx_r)
      2'd0:    last_word_s = 1'b0;
      2'd1:    last_word_s = (dlc_data_words(rx_dlc_s) == 2'd0);
      2'd2:    last_word_s = (dlc_data_words(dlc_r) == 2'd1);
      default: last_word_s = 1'b1;
    endcase
  end

  // Next-state logic of the fetch FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) next_state_s = ST_REQ;
        else next_state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (Can2DEMUX_ack) begin
          if (last_word_s) next_state_s = ST_DONE;
          else next_state_s = ST_GAP;
        end else if (cnt_r == TO_LAST) begin
          next_state_s = ST_ERR;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_GAP:  next_state_s = ST_REQ;
      ST_DONE: begin
        if (frame_ready) next_state_s = ST_IDLE;
        else next_state_s = ST_DONE;
      end
      ST_ERR:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register, registered strobes and frame capture registers.
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset) begin
      state_r  <= ST_IDLE;
      cs_r     <= 1'b0;
      addr_r   <= 8'h00;
      idx_r    <= 2'd0;
      cnt_r    <= 8'd0;
      id_r     <= 32'h0;
      dw1_r    <= 32'h0;
      dw2_r    <= 32'h0;
      dlc_r    <= 4'd0;
      is_hpb_r <= 1'b0;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cs_r    <= (next_state_s == ST_REQ);
      valid_r <= (next_state_s == ST_DONE);
      err_r   <= (next_state_s == ST_ERR);
      busy_r  <= (next_state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            addr_r   <= hpb_sel_s ? HPB_ID_ADDR : FIFO_ID_ADDR;
            is_hpb_r <= hpb_sel_s;
            idx_r    <= 2'd0;
            cnt_r    <= 8'd0;
            id_r     <= 32'h0;
            dw1_r    <= 32'h0;
            dw2_r    <= 32'h0;
            dlc_r    <= 4'd0;
          end
        end
        ST_REQ: begin
          if (Can2DEMUX_ack) begin
            cnt_r <= 8'd0;
            case (idx_r)
              2'd0:    id_r  <= Can2DEMUX_data;
              2'd1:    dlc_r <= rx_dlc_s;
              2'd2:    dw1_r <= Can2DEMUX_data;
              default: dw2_r <= Can2DEMUX_data;
            endcase
          end else if (next_state_s == ST_ERR) begin
            // An aborted fetch must not leave a partial frame behind.
            cnt_r    <= 8'd0;
            id_r     <= 32'h0;
            dw1_r    <= 32'h0;
            dw2_r    <= 32'h0;
            dlc_r    <= 4'd0;
            is_hpb_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_GAP: begin
          idx_r  <= idx_r + 2'd1;
          addr_r <= addr_r + WORD_STRIDE;
        end
        default: begin
        end
      endcase
    end
  end

  assign DEMUX2Can_CS   = cs_r;
  assign DEMUX2Can_addr = addr_r;
  assign frame_valid    = valid_r;
  assign frame_id       = id_r;
  assign frame_dlc      = dlc_r;
  assign frame_data     = {dw1_r, dw2_r};
  assign frame_is_hpb   = is_hpb_r;
  assign fetch_error    = err_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_can_tx_fetch.sv
// Self-checking bench for can_tx_fetch: a register-block model with 2-cycle ack latency
// serves reads, and each scenario compares the DUT against expectations derived from the frame rules.
module tb_can_tx_fetch;

  logic        sys_clk = 1'b0;
  logic        IP2Can_reset = 1'b1;
  logic        tx_req = 1'b0;
  logic        hpb_req = 1'b0;
  logic        DEMUX2Can_CS;
  logic [7:0]  DEMUX2Can_addr;
  logic [31:0] Can2DEMUX_data;
  logic        Can2DEMUX_ack;
  logic        frame_valid;
  logic        frame_ready = 1'b1;
  logic [31:0] frame_id;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic        frame_is_hpb;
  logic        fetch_error;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [0:7];
  bit          ack_en = 1'b1;
  logic [7:0]  reads[$];
  int          gaps[$];
  int          hi_runs[$];

  can_tx_fetch #(.TIMEOUT_CYCLES(15)) dut (
    .sys_clk(sys_clk), .IP2Can_reset(IP2Can_reset), .tx_req(tx_req), .hpb_req(hpb_req),
    .DEMUX2Can_CS(DEMUX2Can_CS), .DEMUX2Can_addr(DEMUX2Can_addr),
    .Can2DEMUX_data(Can2DEMUX_data), .Can2DEMUX_ack(Can2DEMUX_ack),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_id(frame_id),
    .frame_dlc(frame_dlc), .frame_data(frame_data), .frame_is_hpb(frame_is_hpb),
    .fetch_error(fetch_error), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Register block model: ack on the third consecutive CS-high cycle; logs reads, CS runs and gaps.
  initial begin : regblock
    int cs_cnt, gap_len, a;
    bit prev_cs, in_gap;
    cs_cnt = 0; gap_len = 0; prev_cs = 1'b0; in_gap = 1'b0;
    Can2DEMUX_ack = 1'b0; Can2DEMUX_data = 32'h0;
    forever begin
      @(negedge sys_clk);
      if (DEMUX2Can_CS) begin
        if (!prev_cs) begin
          reads.push_back(DEMUX2Can_addr);
          if (in_gap) gaps.push_back(gap_len);
        end
        cs_cnt++;
      end else begin
        if (prev_cs) begin
          hi_runs.push_back(cs_cnt);
          gap_len = 0;
          in_gap = 1'b1;
        end
        cs_cnt = 0;
        gap_len++;
        if (!busy) in_gap = 1'b0;
      end
      prev_cs = DEMUX2Can_CS;
      a = int'(DEMUX2Can_addr) / 4 - 12;
      Can2DEMUX_data = (DEMUX2Can_CS && a >= 0 && a < 8) ? mem[a] : 32'h0;
      Can2DEMUX_ack = ack_en && DEMUX2Can_CS && (cs_cnt == 3);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    IP2Can_reset = 1'b1; tx_req = 1'b0; hpb_req = 1'b0; frame_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_cmp++; if (DEMUX2Can_CS !== 1'b0) begin n_err++; $display("FAIL reset_cs: got %b want 0", DEMUX2Can_CS); end
    n_cmp++; if (DEMUX2Can_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", DEMUX2Can_addr); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
    n_cmp++; if ({frame_id, frame_dlc, frame_data} !== 100'h0) begin n_err++; $display("FAIL reset_frame: id=%h dlc=%h data=%h want 0", frame_id, frame_dlc, frame_data); end
    n_cmp++; if ({frame_is_hpb, fetch_error, busy} !== 3'b000) begin n_err++; $display("FAIL reset_flags: hpb/err/busy=%b want 000", {frame_is_hpb, fetch_error, busy}); end
    IP2Can_reset = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_frame(input string nm, input logic [31:0] id, input logic [31:0] dlcw,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input bit rq_tx, input bit rq_hpb);
    bit src_hpb, seen;
    logic [3:0] raw, edlc;
    logic [7:0] base;
    logic [31:0] eid;
    logic [63:0] edata;
    int nw, ecyc, cyc, bad;
    mem[0] = id;  mem[1] = dlcw; mem[2] = d1;  mem[3] = d2;
    mem[4] = ~id; mem[5] = dlcw; mem[6] = ~d1; mem[7] = ~d2;
`ifdef CAN_TX_HPB_EN
    src_hpb = rq_hpb;
`else
    src_hpb = 1'b0;
`endif
    raw   = dlcw[31:28];
    edlc  = (raw > 4'd8) ? 4'd8 : raw;
    nw    = (edlc == 4'd0) ? 0 : ((edlc <= 4'd4) ? 1 : 2);
    ecyc  = 8 + 4 * nw;
    base  = src_hpb ? 8'h40 : 8'h30;
    eid   = src_hpb ? ~id : id;
    edata = {(nw >= 1) ? (src_hpb ? ~d1 : d1) : 32'h0, (nw >= 2) ? (src_hpb ? ~d2 : d2) : 32'h0};
    reads.delete(); gaps.delete(); hi_runs.delete();
    @(negedge sys_clk);
    tx_req = rq_tx; hpb_req = rq_hpb; frame_ready = 1'b1;
    cyc = 0; seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge sys_clk);
      if (c == 1) begin tx_req = 1'b0; hpb_req = 1'b0; end
      if (frame_valid) begin seen = 1'b1; cyc = c; end
    end
    n_cmp++; if (cyc !== ecyc) begin n_err++; $display("FAIL %s valid_cycle: got %0d want %0d", nm, cyc, ecyc); end
    n_cmp++; if (frame_id !== eid) begin n_err++; $display("FAIL %s id: got %h want %h", nm, frame_id, eid); end
    n_cmp++; if (frame_dlc !== edlc) begin n_err++; $display("FAIL %s dlc: got %0d want %0d", nm, frame_dlc, edlc); end
    n_cmp++; if (frame_data !== edata) begin n_err++; $display("FAIL %s data: got %h want %h", nm, frame_data, edata); end
    n_cmp++; if (frame_is_hpb !== src_hpb) begin n_err++; $display("FAIL %s is_hpb: got %b want %b", nm, frame_is_hpb, src_hpb); end
    @(negedge sys_clk);
    n_cmp++; if ({frame_valid, busy} !== 2'b00) begin n_err++; $display("FAIL %s after_accept valid/busy: got %b want 00", nm, {frame_valid, busy}); end
    n_cmp++; if (reads.size() !== 2 + nw) begin n_err++; $display("FAIL %s read_count: got %0d want %0d", nm, reads.size(), 2 + nw); end
    for (int i = 0; i < reads.size() && i < 2 + nw; i++) begin
      n_cmp++;
      if (reads[i] !== base + 8'(4 * i)) begin n_err++; $display("FAIL %s addr%0d: got %h want %h", nm, i, reads[i], base + 8'(4 * i)); end
    end
    bad = 0;
    foreach (gaps[i]) if (gaps[i] != 1) bad++;
    foreach (hi_runs[i]) if (hi_runs[i] != 3) bad++;
    n_cmp++; if (bad !== 0 || gaps.size() !== 1 + nw) begin n_err++; $display("FAIL %s cs_shape: %0d bad runs, %0d gaps want %0d", nm, bad, gaps.size(), 1 + nw); end
  endtask

  task automatic test_timeout();
    int cs_hi, err_cyc, err_cnt;
    bit vseen;
    cs_hi = 0; err_cyc = 0; err_cnt = 0; vseen = 1'b0;
    ack_en = 1'b0;
    @(negedge sys_clk);
    tx_req = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge sys_clk);
      if (c == 1) tx_req = 1'b0;
      if (DEMUX2Can_CS) cs_hi++;
      if (fetch_error) begin err_cnt++; if (err_cyc == 0) err_cyc = c; end
      if (frame_valid) vseen = 1'b1;
    end
    ack_en = 1'b1;
    n_cmp++; if (cs_hi !== 15) begin n_err++; $display("FAIL timeout_cs_cycles: got %0d want 15", cs_hi); end
    n_cmp++; if (err_cyc !== 16) begin n_err++; $display("FAIL timeout_err_cycle: got %0d want 16", err_cyc); end
    n_cmp++; if (err_cnt !== 1) begin n_err++; $display("FAIL timeout_err_width: got %0d want 1", err_cnt); end
    n_cmp++; if (vseen !== 1'b0) begin n_err++; $display("FAIL timeout_valid: got %b want 0", vseen); end
    n_cmp++; if ({busy, DEMUX2Can_CS, frame_id, frame_data} !== 98'h0) begin n_err++; $display("FAIL timeout_idle: busy=%b cs=%b id=%h data=%h want 0", busy, DEMUX2Can_CS, frame_id, frame_data); end
  endtask

  task automatic test_reset_mid();
    bit hit, vseen;
    hit = 1'b0; vseen = 1'b0;
    mem[0] = 32'h12340000; mem[1] = 32'h80000000; mem[2] = 32'hAABBCCDD; mem[3] = 32'h11223344;
    @(negedge sys_clk);
    tx_req = 1'b1;
    for (int c = 1; c <= 30 && !hit; c++) begin
      @(negedge sys_clk);
      if (c == 1) tx_req = 1'b0;
      if (DEMUX2Can_CS && DEMUX2Can_addr == 8'h38) hit = 1'b1;
    end
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_dw1: got %b want 1", hit); end
    IP2Can_reset = 1'b1;
    @(negedge sys_clk);
    n_cmp++; if ({DEMUX2Can_CS, frame_valid, busy, fetch_error} !== 4'b0) begin n_err++; $display("FAIL rstmid_ctrl: cs/valid/busy/err=%b want 0000", {DEMUX2Can_CS, frame_valid, busy, fetch_error}); end
    n_cmp++; if ({DEMUX2Can_addr, frame_id, frame_dlc, frame_data, frame_is_hpb} !== 109'h0) begin n_err++; $display("FAIL rstmid_regs: addr=%h id=%h dlc=%h data=%h want 0", DEMUX2Can_addr, frame_id, frame_dlc, frame_data); end
    IP2Can_reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (frame_valid || DEMUX2Can_CS) vseen = 1'b1;
    end
    n_cmp++; if (vseen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_partial: got activity %b want 0", vseen); end
  endtask

  task automatic test_stall();
    logic [31:0] d1;
    int cyc, bad;
    bit seen;
    d1 = $urandom;
    mem[0] = 32'hCAFE0001; mem[1] = 32'h20000000; mem[2] = d1; mem[3] = 32'h55555555;
    cyc = 0; bad = 0; seen = 1'b0;
    @(negedge sys_clk);
    tx_req = 1'b1; frame_ready = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge sys_clk);
      if (c == 1) tx_req = 1'b0;
      if (frame_valid) begin seen = 1'b1; cyc = c; end
    end
    n_cmp++; if (cyc !== 12) begin n_err++; $display("FAIL stall_valid_cycle: got %0d want 12", cyc); end
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      if (frame_valid !== 1'b1 || frame_id !== 32'hCAFE0001 || frame_dlc !== 4'd2 ||
          frame_data !== {d1, 32'h0} || busy !== 1'b1 || DEMUX2Can_CS !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_hold: %0d unstable cycles want 0", bad); end
    frame_ready = 1'b1;
    @(negedge sys_clk);
    n_cmp++; if ({frame_valid, busy} !== 2'b00) begin n_err++; $display("FAIL stall_release valid/busy: got %b want 00", {frame_valid, busy}); end
  endtask

  task automatic test_random();
    logic [31:0] dlcw;
    for (int i = 0; i < 10; i++) begin
      dlcw = {4'($urandom_range(0, 15)), 28'($urandom)};
      test_frame("random", $urandom, dlcw, $urandom, $urandom, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin : main
    test_reset();
    test_frame("fifo_dlc8", 32'h12340000, 32'h80000000, 32'hAABBCCDD, 32'h11223344, 1'b1, 1'b0);
    test_frame("fifo_dlc3", 32'h00000123, 32'h30000000, 32'hDEADBEEF, 32'h0BADF00D, 1'b1, 1'b0);
    test_frame("fifo_dlc15", 32'h1FFFFFFF, 32'hF0000000, 32'h01020304, 32'h05060708, 1'b1, 1'b0);
    test_frame("fifo_dlc0", 32'h00000042, 32'h00000000, 32'h99999999, 32'h77777777, 1'b1, 1'b0);
    test_timeout();
    test_frame("hpb_prio", 32'h0000ABCD, 32'h50000000, 32'h13579BDF, 32'h2468ACE0, 1'b1, 1'b1);
    test_reset_mid();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/can_tx_fetch.md
# can_tx_fetch

Transmit-frame fetch stage sitting between the CAN register block and the transmit bit-stream processor. On a transmit request it reads the TX FIFO message registers, or the high-priority buffer (HPB) when enabled, over the DEMUX read port. Each read is a CS/addr/ack handshake. It then presents the assembled frame (ID, DLC, up to 8 data bytes) downstream with a valid/ready handshake. Data words that the DLC makes unnecessary are skipped, and a stalled read is aborted by a timeout.

## Interface
- TIMEOUT_CYCLES, 15: maximum REQ cycles to wait for ack before aborting (≥4).
- sys_clk  in  1  single clock.
- IP2Can_reset  in  1  synchronous, active-high reset.
- tx_req  in  1  level; fetch TX FIFO frame, sampled only in IDLE.
- hpb_req  in  1  level; fetch HPB frame, sampled only in IDLE (ignored unless macro defined).
- DEMUX2Can_CS  out  1  read strobe to register block.
- DEMUX2Can_addr  out  8  register address.
- Can2DEMUX_data  in  32  read data.
- Can2DEMUX_ack  in  1  read acknowledge.
- frame_valid  out  1  assembled frame available.
- frame_ready  in  1  downstream accepts frame.
- frame_id  out  32  ID register word.
- frame_dlc  out  4  clamped DLC (0–8).
- frame_data  out  64  {dataword1, dataword2}; unread words are zero.
- frame_is_hpb  out  1  frame came from HPB.
- fetch_error  out  1  one-cycle pulse on timeout abort.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, REQ, GAP, DONE, ERR.
- IDLE: if hpb_req (macro on), select HPB base 0x40; else if tx_req, select FIFO base 0x30; go REQ with word index 0. Both requests high selects HPB.
- Word order: ID (base+0x0), DLC (base+0x4), DW1 (base+0x8), DW2 (base+0xC).
- REQ: CS=1 and addr=base+4·index.
  - Cycle counter increments each cycle.
  - On the cycle with ack=1, capture Can2DEMUX_data into the word slot, clear the counter, and drop CS on the next edge.
  - If there are more words, go GAP; if not, go DONE.
  - If the counter reaches TIMEOUT_CYCLES with no ack, go ERR.
- GAP: CS=0 for exactly one cycle so the register block resets its ack counter; then REQ with index+1.
- DLC decode: raw = DLC word[31:28]; frame_dlc = min(raw, 8).
  - Words needed after DLC: 0 for frame_dlc 0; 1 for frame_dlc 1–4; 2 for frame_dlc 5–8.
- DONE: frame_valid=1 and all frame outputs held stable. frame_valid && frame_ready goes to IDLE the next cycle; a new fetch cannot start in the same cycle.
- ERR: fetch_error=1 for one cycle, frame registers cleared, then go IDLE. No frame_valid is produced.
- Requests are level-sensitive. A request held high after DONE starts a new fetch of the same registers; upstream must deassert it.
- frame_data and frame_id are cleared at the start of each fetch.

## Timing
- Reset values: DEMUX2Can_CS=0, DEMUX2Can_addr=0x00, frame_valid=0, frame_id=0, frame_dlc=0, frame_data=0, frame_is_hpb=0, fetch_error=0, busy=0. State is IDLE.
- Reset asserted mid-fetch: CS drops on the same edge and nothing partial is emitted.
- Ack latency of the register block is 2 cycles after CS rises, so one REQ lasts 3 cycles and each word costs 4 cycles including GAP.
- Measured from the IDLE cycle that samples the request (cycle 0): frame_valid first high at cycle 8 (DLC 0), cycle 12 (DLC 1–4), cycle 16 (DLC 5–8).
- An ack seen outside REQ is ignored.

## Configuration
- CAN_TX_HPB_EN defined: hpb_req is honoured with priority over tx_req, and frame_is_hpb reflects the source.
- CAN_TX_HPB_EN not defined: hpb_req is ignored, only base 0x30 is used, and frame_is_hpb stays 0.

## Structure
- Package can_tx_fetch_pkg holds:
  - the state enum;
  - address constants for TX FIFO 0x30–0x3C and HPB 0x40–0x4C;
  - the DLC field position [31:28] and maximum DLC 8;
  - a function mapping frame_dlc to the number of data words.
- Single module with no sub-module; the FSM and capture registers stay in can_tx_fetch.

## Test plan
- FIFO frame: ID=0x12340000, DLC word=0x80000000, DW1=0xAABBCCDD, DW2=0x11223344, tx_req. Expect 4 reads at 0x30/0x34/0x38/0x3C, CS low one cycle between them, frame_valid at cycle 16, frame_data=0xAABBCCDD11223344, frame_dlc=8.
- DLC word=0x30000000. Expect only 3 reads (no 0x3C), frame_valid at cycle 12, frame_data[31:0]=0.
- DLC word=0xF0000000. Expect frame_dlc=8 and DW2 read. With DLC word=0x00000000, expect no data reads and frame_valid at cycle 8.
- Ack never returned with TIMEOUT_CYCLES=15. Expect CS high for 15 cycles, then fetch_error pulse, CS=0, IDLE, and frame_valid never asserted.
- With CAN_TX_HPB_EN, tx_req and hpb_req raised together. Expect the first address 0x40 and frame_is_hpb=1. Without the macro, expect the first address 0x30.
- Reset asserted during the DW1 read, and frame_ready held low in DONE for 5 cycles. After reset, expect all outputs at reset values. During the stall, expect frame outputs stable and IDLE one cycle after frame_ready rises.
